// File: rtl/mul32_mac_seq_pkg.sv
// Shared types, step table and carry-save helpers for the 32x32 multiply-accumulate sequencer.
package mul_pkg;

    typedef logic [15:0] w16_t;
    typedef logic [31:0] w32_t;
    typedef logic [63:0] w64_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Left shift applied to the partial product of each MUL step (lo*lo, hi*lo, lo*hi, hi*hi).
    localparam int STEP_SHIFT [4] = '{0, 16, 16, 32};

    // 64-bit 3:2 compressor; returns {carry<<1, sum}, carry out of bit 63 is dropped.
    function automatic logic [127:0] csa_3_2_w64(input w64_t x, input w64_t y, input w64_t z);
        w64_t sum;
        w64_t carry;
        sum   = x ^ y ^ z;
        carry = (x & y) | (x & z) | (y & z);
        return {carry << 1, sum};
    endfunction

    // 32-bit 3:2 compressor used inside the Booth core; returns {carry<<1, sum}.
    function automatic logic [63:0] csa_3_2_w32(input w32_t x, input w32_t y, input w32_t z);
        w32_t sum;
        w32_t carry;
        sum   = x ^ y ^ z;
        carry = (x & y) | (x & z) | (y & z);
        return {carry << 1, sum};
    endfunction

    // Radix-4 Booth partial product for a 3-bit window, as a 32-bit two's complement value.
    function automatic w32_t booth_pp(input w16_t a, input logic [2:0] sel);
        w32_t mag;
        w32_t res;
        mag = '0;
        res = '0;
        case (sel)
            3'b001, 3'b010: res = {16'd0, a};
            3'b011:         res = {15'd0, a, 1'b0};
            3'b100: begin
                mag = {15'd0, a, 1'b0};
                res = ~mag + 32'd1;
            end
            3'b101, 3'b110: begin
                mag = {16'd0, a};
                res = ~mag + 32'd1;
            end
            default:        res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mul32_mac_seq_if.sv
// Request/result handshake bundle between a requester and the multiply-accumulate sequencer.
interface mul32_mac_seq_if;
    import mul_pkg::*;

    logic  in_valid;
    logic  in_ready;
    w32_t  in_a;
    w32_t  in_b;
    w64_t  in_c;
    logic  in_acc;
    logic  out_valid;
    logic  out_ready;
    w64_t  out_y;
    logic  busy;

    modport master (
        output in_valid, in_a, in_b, in_c, in_acc, out_ready,
        input  in_ready, out_valid, out_y, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_acc, out_ready,
        output in_ready, out_valid, out_y, busy
    );

endinterface

// File: rtl/mul32_mac_seq_mul16_cs.sv
// Combinational 16x16 unsigned radix-4 Booth multiplier left in carry-save form:
// y_1 + y_2 == a*b (mod 2^32). Nine Booth digits cover the 16 unsigned bits plus a zero sign.
module mul16_cs
    import mul_pkg::*;
(
    input  w16_t a,
    input  w16_t b,
    output w32_t y_1,
    output w32_t y_2
);

    logic [18:0] bx;
    w32_t        s_acc;
    w32_t        c_acc;
    w32_t        pp_i;
    logic [63:0] r32;

    // Window source: two zero bits above b make the top digit non-negative, the low zero starts Booth.
    assign bx = {2'b00, b, 1'b0};

    // Fold the nine shifted Booth partial products through a linear chain of 3:2 compressors.
    always_comb begin
        s_acc = booth_pp(a, bx[2:0]);
        c_acc = '0;
        pp_i  = '0;
        r32   = '0;
        for (int i = 1; i < 9; i++) begin
            pp_i  = booth_pp(a, bx[2*i +: 3]) << (2 * i);
            r32   = csa_3_2_w32(s_acc, c_acc, pp_i);
            c_acc = r32[63:32];
            s_acc = r32[31:0];
        end
    end

    assign y_1 = s_acc;
    assign y_2 = c_acc;

endmodule

// File: rtl/mul32_mac_seq.sv
// Iterative 32x32 unsigned multiply-accumulate: y = a*b + c (mod 2^64).
// One 16x16 Booth core is time-shared over four steps; passes accumulate in a 64-bit
// carry-save pair which is resolved by a single final add.
module mul32_mac_seq
    import mul_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mul32_mac_seq_if.slave bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_MUL  = MUL;
    localparam logic [1:0] ST_ADD  = ADD;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]   state;
    logic [1:0]   step;
    w32_t         a_r;
    w32_t         b_r;
    w64_t         acc_s;
    w64_t         acc_c;
    logic         out_valid_r;
    w64_t         out_y_r;

    logic         accept;
    w64_t         addend;
    w16_t         core_a;
    w16_t         core_b;
    w32_t         core_y1;
    w32_t         core_y2;
    w32_t         pp;
    w64_t         pp_sh;
    logic [127:0] csa_r;
    w64_t         csa_s;
    w64_t         csa_c;

    // Ready depends only on state and the consumer, never on in_valid.
    assign bus.in_ready  = ~rst & ((state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready));
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_y     = out_y_r;
    assign addend        = bus.in_acc ? bus.in_c : '0;

    // Select which 16-bit halves of a and b feed the core on this step.
    always_comb begin
        core_a = a_r[15:0];
        core_b = b_r[15:0];
        case (step)
            2'd0: begin core_a = a_r[15:0];  core_b = b_r[15:0];  end
            2'd1: begin core_a = a_r[31:16]; core_b = b_r[15:0];  end
            2'd2: begin core_a = a_r[15:0];  core_b = b_r[31:16]; end
            default: begin core_a = a_r[31:16]; core_b = b_r[31:16]; end
        endcase
    end

    mul16_cs u_core (
        .a   (core_a),
        .b   (core_b),
        .y_1 (core_y1),
        .y_2 (core_y2)
    );

    // The core pair is resolved to the exact 32-bit partial product before weighting.
    assign pp    = core_y1 + core_y2;
    assign pp_sh = w64_t'(pp) << STEP_SHIFT[step];
    assign csa_r = csa_3_2_w64(pp_sh, acc_s, acc_c);
    assign csa_c = csa_r[127:64];
    assign csa_s = csa_r[63:0];

    // Operand capture on accept; these are only read while the FSM is in MUL, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= bus.in_a;
            b_r <= bus.in_b;
        end
    end

    // Control FSM, step counter, carry-save accumulator and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            step        <= 2'd0;
            out_valid_r <= 1'b0;
            out_y_r     <= '0;
            acc_s       <= '0;
            acc_c       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc_s <= addend;
                        acc_c <= '0;
                        step  <= 2'd0;
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_s <= csa_s;
                    acc_c <= csa_c;
                    step  <= step + 2'd1;
                    if (step == 2'd3) begin
                        state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    out_y_r     <= acc_s + acc_c;
                    out_valid_r <= 1'b1;
                    state       <= ST_DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (accept) begin
                            acc_s <= addend;
                            acc_c <= '0;
                            step  <= 2'd0;
                            state <= ST_MUL;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
